// File: rtl/reg_field_encoder_pipe.sv
// reg_field_encoder_pipe
//   Encodes NUM_SRC raw 10-bit operand fields into 12-bit register-file
//   operand codes. Optionally fetches one shared 32-bit literal and holds
//   the result until the consumer takes it.
//
//   Config macro: REG_ENC_FP_CONST_EN enables the inline float constants
//   (0x2F0..0x2F7). When it is undefined those codes are reserved.
//
//   Ports
//     clk, rst_n           clock, async active-low reset
//     flush                synchronous drop of in-flight work
//     in_valid/in_ready    request handshake; in_fields[10i+9:10i] = channel i
//     sgpr_base, vgpr_base register bases sampled at acceptance
//     out_valid/out_ready  result handshake
//     out_fields           12-bit encoding per channel
//     out_fp_valid/value   per-channel inline float constant
//     out_reserved         per-channel unlisted/reserved code flag
//     explicit_*           implicit-register use, OR across channels
//     out_literal(_req'd)  literal captured for this result
//     lit_req/valid/data   literal fetch handshake
module reg_field_encoder_pipe #(
    parameter int NUM_SRC = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [10*NUM_SRC-1:0] in_fields,
    input  logic [8:0]            sgpr_base,
    input  logic [9:0]            vgpr_base,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [12*NUM_SRC-1:0] out_fields,
    output logic [NUM_SRC-1:0]    out_fp_valid,
    output logic [32*NUM_SRC-1:0] out_fp_value,
    output logic [NUM_SRC-1:0]    out_reserved,
    output logic                  explicit_vcc,
    output logic                  explicit_exec,
    output logic                  explicit_scc,
    output logic                  explicit_m0,
    output logic                  out_literal_required,
    output logic [31:0]           out_literal,
    output logic                  lit_req,
    input  logic                  lit_valid,
    input  logic [31:0]           lit_data
);

    typedef enum logic [1:0] {IDLE, LIT_WAIT, OUT_HOLD} state_t;

    typedef struct packed {
        logic [11:0] enc;
        logic        fp_valid;
        logic [31:0] fp_value;
        logic        rsv;
        logic        vcc;
        logic        exec;
        logic        scc;
        logic        m0;
        logic        lit;
    } lane_enc_t;

`ifdef REG_ENC_FP_CONST_EN
    // +-0.5, +-1, +-2, +-4 in IEEE-754 single precision.
    function automatic logic [31:0] fp_const(input logic [2:0] idx);
        logic [31:0] v;
        case (idx)
            3'd0:    v = 32'h3F00_0000;
            3'd1:    v = 32'hBF00_0000;
            3'd2:    v = 32'h3F80_0000;
            3'd3:    v = 32'hBF80_0000;
            3'd4:    v = 32'h4000_0000;
            3'd5:    v = 32'hC000_0000;
            3'd6:    v = 32'h4080_0000;
            default: v = 32'hC080_0000;
        endcase
        return v;
    endfunction
`endif

    function automatic lane_enc_t encode(input logic [9:0] f,
                                         input logic [8:0] sb,
                                         input logic [9:0] vb);
        lane_enc_t  r;
        logic [6:0] code;
        r    = '0;
        code = f[6:0];
        if (!f[9]) begin
            r.rsv = 1'b1;
        end else if (f[8]) begin
            r.enc = {2'b10, vb + {2'b00, f[7:0]}};
        end else if (!f[7]) begin
            if (code <= 7'd103) begin
                r.enc = {3'b110, sb + {2'b00, code}};
            end else begin
                case (code)
                    7'd106:  begin r.enc = 12'hE01; r.vcc  = 1'b1; end
                    7'd107:  begin r.enc = 12'hE02; r.vcc  = 1'b1; end
                    7'd124:  begin r.enc = 12'hE04; r.m0   = 1'b1; end
                    7'd126:  begin r.enc = 12'hE08; r.exec = 1'b1; end
                    7'd127:  begin r.enc = 12'hE10; r.exec = 1'b1; end
                    default: r.rsv = 1'b1;
                endcase
            end
        end else begin
            if (code <= 7'd64) begin
                r.enc = {5'd0, code};
            end else if (code <= 7'd80) begin
                // 65..80 map to -1..-16: f[5:0] is the magnitude.
                r.enc = {2'b00, 10'd0 - {4'd0, f[5:0]}};
            end else begin
                case (code)
                    7'd123:  begin r.enc = 12'hE20; r.vcc  = 1'b1; end
                    7'd124:  begin r.enc = 12'hE40; r.exec = 1'b1; end
                    7'd125:  begin r.enc = 12'hE80; r.scc  = 1'b1; end
                    7'd127:  begin r.enc = 12'h7FF; r.lit  = 1'b1; end
                    default: begin
`ifdef REG_ENC_FP_CONST_EN
                        if (code[6:3] == 4'b1110) begin
                            r.enc      = 12'h7FF;
                            r.fp_valid = 1'b1;
                            r.fp_value = fp_const(code[2:0]);
                        end else begin
                            r.rsv = 1'b1;
                        end
`else
                        r.rsv = 1'b1;
`endif
                    end
                endcase
            end
        end
        return r;
    endfunction

    lane_enc_t lane [NUM_SRC];

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_lane
        assign lane[i] = encode(in_fields[10*i +: 10], sgpr_base, vgpr_base);
    end

    // Gather per-lane encodings into the packed output layout.
    logic [12*NUM_SRC-1:0] enc_fields;
    logic [NUM_SRC-1:0]    enc_fp_valid, enc_rsv;
    logic [32*NUM_SRC-1:0] enc_fp_value;
    logic                  any_vcc, any_exec, any_scc, any_m0, any_lit;

    always_comb begin
        enc_fields   = '0;
        enc_fp_valid = '0;
        enc_fp_value = '0;
        enc_rsv      = '0;
        any_vcc      = 1'b0;
        any_exec     = 1'b0;
        any_scc      = 1'b0;
        any_m0       = 1'b0;
        any_lit      = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            enc_fields[12*i +: 12]   = lane[i].enc;
            enc_fp_valid[i]          = lane[i].fp_valid;
            enc_fp_value[32*i +: 32] = lane[i].fp_value;
            enc_rsv[i]               = lane[i].rsv;
            any_vcc                  = any_vcc  | lane[i].vcc;
            any_exec                 = any_exec | lane[i].exec;
            any_scc                  = any_scc  | lane[i].scc;
            any_m0                   = any_m0   | lane[i].m0;
            any_lit                  = any_lit  | lane[i].lit;
        end
    end

    state_t                state_q, state_d;
    logic                  out_valid_q, out_valid_d;
    logic                  lit_req_q, lit_req_d;
    logic [12*NUM_SRC-1:0] fields_q, fields_d;
    logic [NUM_SRC-1:0]    fp_valid_q, fp_valid_d, rsv_q, rsv_d;
    logic [32*NUM_SRC-1:0] fp_value_q, fp_value_d;
    logic [3:0]            expl_q, expl_d;    // {m0, scc, exec, vcc}
    logic                  lit_reqd_q, lit_reqd_d;
    logic [31:0]           literal_q, literal_d;
    logic                  accept;

    assign in_ready = !flush && (state_q == IDLE ||
                                 (state_q == OUT_HOLD && out_ready));
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        lit_req_d   = lit_req_q;
        fields_d    = fields_q;
        fp_valid_d  = fp_valid_q;
        fp_value_d  = fp_value_q;
        rsv_d       = rsv_q;
        expl_d      = expl_q;
        lit_reqd_d  = lit_reqd_q;
        literal_d   = literal_q;
        if (flush) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
            lit_req_d   = 1'b0;
        end else if (accept) begin
            // Covers both IDLE and the no-bubble reload out of OUT_HOLD.
            fields_d    = enc_fields;
            fp_valid_d  = enc_fp_valid;
            fp_value_d  = enc_fp_value;
            rsv_d       = enc_rsv;
            expl_d      = {any_m0, any_scc, any_exec, any_vcc};
            lit_reqd_d  = any_lit;
            literal_d   = '0;
            state_d     = any_lit ? LIT_WAIT : OUT_HOLD;
            out_valid_d = !any_lit;
            lit_req_d   = any_lit;
        end else begin
            case (state_q)
                LIT_WAIT: if (lit_valid) begin
                    literal_d   = lit_data;
                    state_d     = OUT_HOLD;
                    out_valid_d = 1'b1;
                    lit_req_d   = 1'b0;
                end
                OUT_HOLD: if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            lit_req_q   <= 1'b0;
            fields_q    <= '0;
            fp_valid_q  <= '0;
            fp_value_q  <= '0;
            rsv_q       <= '0;
            expl_q      <= '0;
            lit_reqd_q  <= 1'b0;
            literal_q   <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            lit_req_q   <= lit_req_d;
            fields_q    <= fields_d;
            fp_valid_q  <= fp_valid_d;
            fp_value_q  <= fp_value_d;
            rsv_q       <= rsv_d;
            expl_q      <= expl_d;
            lit_reqd_q  <= lit_reqd_d;
            literal_q   <= literal_d;
        end
    end

    assign out_valid            = out_valid_q;
    assign lit_req              = lit_req_q;
    assign out_fields           = fields_q;
    assign out_fp_valid         = fp_valid_q;
    assign out_fp_value         = fp_value_q;
    assign out_reserved         = rsv_q;
    assign explicit_vcc         = expl_q[0];
    assign explicit_exec        = expl_q[1];
    assign explicit_scc         = expl_q[2];
    assign explicit_m0          = expl_q[3];
    assign out_literal_required = lit_reqd_q;
    assign out_literal          = literal_q;

endmodule
